// File: rtl/p405s_icu_fill_pkg.sv
// Shared types and defaults for the ICU line-fill read path.
// Optional parity storage is enabled with ICU_FILL_PARITY_EN.
package p405s_icu_fill_pkg;

    localparam int DW_DEF    = 32;
    localparam int WORDS_DEF = 8;
    localparam int IDXW_DEF  = 3;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } state_e;

    function automatic int unsigned wrap_inc(
        input int unsigned idx,
        input int unsigned words
    );
        return (idx + 1) % words;
    endfunction

endpackage

// File: rtl/p405s_icu_fill_ptr.sv
// Read pointer and consumed-word counter for the fill buffer.
// Priority: clear, then load, then increment.
module p405s_icu_fill_ptr
    import p405s_icu_fill_pkg::*;
#(
    parameter int WORDS = WORDS_DEF,
    parameter int IDXW  = IDXW_DEF
) (
    input  logic            CB,
    input  logic            RST_N,
    input  logic            load_i,
    input  logic [IDXW-1:0] load_idx_i,
    input  logic            inc_i,
    input  logic            clr_i,
    output logic [IDXW-1:0] rdptr_o,
    output logic            last_o
);

    logic [IDXW-1:0] rdptr_q, rdptr_d;
    logic [IDXW-1:0] cnt_q, cnt_d;

    always_comb begin
        rdptr_d = rdptr_q;
        cnt_d   = cnt_q;
        if (clr_i) begin
            rdptr_d = '0;
            cnt_d   = '0;
        end else if (load_i) begin
            rdptr_d = load_idx_i;
            cnt_d   = '0;
        end else if (inc_i) begin
            rdptr_d = IDXW'(wrap_inc(int'(rdptr_q), WORDS));
            cnt_d   = cnt_q + IDXW'(1);
        end
    end

    always_ff @(posedge CB or negedge RST_N) begin
        if (!RST_N) begin
            rdptr_q <= '0;
            cnt_q   <= '0;
        end else begin
            rdptr_q <= rdptr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign rdptr_o = rdptr_q;
    assign last_o  = (cnt_q == IDXW'(WORDS - 1));

endmodule

// File: rtl/p405s_icu_fill_reader.sv
// ICU line-fill reader: captures PLB words in any order, replays critical-word-first.
// Define ICU_FILL_PARITY_EN to add per-word parity storage and FETCH_PERR.
module p405s_icu_fill_reader
    import p405s_icu_fill_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int WORDS = WORDS_DEF,
    parameter int IDXW  = IDXW_DEF
) (
    input  logic            CB,
    input  logic            RST_N,
    input  logic            FILL_START,
    input  logic [IDXW-1:0] FILL_CRIT_IDX,
    input  logic            FILL_ABORT,
    input  logic            PLB_DVAL,
    input  logic [IDXW-1:0] PLB_WIDX,
    input  logic [0:DW-1]   PLB_DATA,
`ifdef ICU_FILL_PARITY_EN
    input  logic            PLB_DPAR,
    output logic            FETCH_PERR,
`endif
    input  logic            FETCH_HOLD,
    output logic            FETCH_VAL,
    output logic [IDXW-1:0] FETCH_IDX,
    output logic [0:DW-1]   FETCH_DATA,
    output logic            LINE_DONE,
    output logic            BUSY
);

    state_e           state_q, state_d;
    logic [WORDS-1:0] vld_q, vld_d;
    logic             done_q, done_d;
    logic [0:DW-1]    mem_q [WORDS];

    logic            wr_en;
    logic            ld, inc, clr;
    logic            last;
    logic            consume;
    logic [IDXW-1:0] rdptr;

    p405s_icu_fill_ptr #(
        .WORDS (WORDS),
        .IDXW  (IDXW)
    ) u_ptr (
        .CB         (CB),
        .RST_N      (RST_N),
        .load_i     (ld),
        .load_idx_i (FILL_CRIT_IDX),
        .inc_i      (inc),
        .clr_i      (clr),
        .rdptr_o    (rdptr),
        .last_o     (last)
    );

    assign BUSY      = (state_q == ST_STREAM);
    assign FETCH_VAL = BUSY && vld_q[rdptr];
    assign FETCH_IDX = rdptr;
    assign FETCH_DATA = FETCH_VAL ? mem_q[rdptr] : '0;
    assign LINE_DONE = done_q;
    assign consume   = FETCH_VAL && !FETCH_HOLD;

    always_comb begin
        state_d = state_q;
        vld_d   = vld_q;
        done_d  = 1'b0;
        wr_en   = 1'b0;
        ld      = 1'b0;
        inc     = 1'b0;
        clr     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (FILL_START && !FILL_ABORT) begin
                    state_d = ST_STREAM;
                    vld_d   = '0;
                    ld      = 1'b1;
                end
            end
            ST_STREAM: begin
                if (FILL_ABORT) begin
                    // Abort drops any same-cycle write and consume.
                    state_d = ST_IDLE;
                    vld_d   = '0;
                    clr     = 1'b1;
                end else begin
                    if (PLB_DVAL && !vld_q[PLB_WIDX]) begin
                        wr_en           = 1'b1;
                        vld_d[PLB_WIDX] = 1'b1;
                    end
                    if (consume) begin
                        inc = 1'b1;
                        if (last) begin
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                            clr     = 1'b1;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CB or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            vld_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vld_q   <= vld_d;
            done_q  <= done_d;
        end
    end

    // Line storage carries no reset; the valid mask qualifies every read.
    always_ff @(posedge CB) begin
        if (wr_en) begin
            mem_q[PLB_WIDX] <= PLB_DATA;
        end
    end

`ifdef ICU_FILL_PARITY_EN
    logic [WORDS-1:0] par_q;

    always_ff @(posedge CB) begin
        if (wr_en) begin
            par_q[PLB_WIDX] <= PLB_DPAR;
        end
    end

    assign FETCH_PERR = FETCH_VAL && (par_q[rdptr] != (^mem_q[rdptr]));
`endif

endmodule

// File: tb/tb_p405s_icu_fill_reader.sv
// Scenario bench for the ICU fill reader with a fetch-side scoreboard.
// Consumed words are popped from the expected queue by a negedge monitor.
module tb_p405s_icu_fill_reader;

    logic        CB;
    logic        RST_N;
    logic        FILL_START;
    logic [2:0]  FILL_CRIT_IDX;
    logic        FILL_ABORT;
    logic        PLB_DVAL;
    logic [2:0]  PLB_WIDX;
    logic [31:0] PLB_DATA;
    logic        FETCH_HOLD;
    logic        FETCH_VAL;
    logic [2:0]  FETCH_IDX;
    logic [31:0] FETCH_DATA;
    logic        LINE_DONE;
    logic        BUSY;
`ifdef ICU_FILL_PARITY_EN
    logic        PLB_DPAR;
    logic        FETCH_PERR;
    assign PLB_DPAR = ^PLB_DATA;
`endif

    typedef struct {
        logic [2:0]  idx;
        logic [31:0] data;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    p405s_icu_fill_reader dut (
        .CB            (CB),
        .RST_N         (RST_N),
        .FILL_START    (FILL_START),
        .FILL_CRIT_IDX (FILL_CRIT_IDX),
        .FILL_ABORT    (FILL_ABORT),
        .PLB_DVAL      (PLB_DVAL),
        .PLB_WIDX      (PLB_WIDX),
        .PLB_DATA      (PLB_DATA),
`ifdef ICU_FILL_PARITY_EN
        .PLB_DPAR      (PLB_DPAR),
        .FETCH_PERR    (FETCH_PERR),
`endif
        .FETCH_HOLD    (FETCH_HOLD),
        .FETCH_VAL     (FETCH_VAL),
        .FETCH_IDX     (FETCH_IDX),
        .FETCH_DATA    (FETCH_DATA),
        .LINE_DONE     (LINE_DONE),
        .BUSY          (BUSY)
    );

    initial CB = 1'b0;
    always #5 CB = ~CB;

    always @(negedge CB) begin
        exp_t e;
        if (RST_N && FETCH_VAL && !FETCH_HOLD && !FILL_ABORT) begin
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL sb_empty: consumed idx=%0d data=%h, expected none",
                         FETCH_IDX, FETCH_DATA);
            end else begin
                e = q.pop_front();
                if (FETCH_IDX !== e.idx || FETCH_DATA !== e.data) begin
                    bad++;
                    $display("FAIL sb_word: got idx=%0d data=%h, want idx=%0d data=%h",
                             FETCH_IDX, FETCH_DATA, e.idx, e.data);
                end
            end
`ifdef ICU_FILL_PARITY_EN
            total++;
            if (FETCH_PERR !== 1'b0) begin
                bad++;
                $display("FAIL perr: got %b want 0", FETCH_PERR);
            end
`endif
        end
    end

    task automatic tick();
        @(posedge CB);
        #1;
    endtask

    task automatic start_fill(input int crit);
        FILL_START    = 1'b1;
        FILL_CRIT_IDX = 3'(crit);
        tick();
        FILL_START    = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) tick();
        total += 5;
        if (FETCH_VAL !== 1'b0) begin bad++; $display("FAIL rst_val: got %b want 0", FETCH_VAL); end
        if (FETCH_IDX !== 3'd0) begin bad++; $display("FAIL rst_idx: got %0d want 0", FETCH_IDX); end
        if (FETCH_DATA !== 32'h0) begin bad++; $display("FAIL rst_data: got %h want 0", FETCH_DATA); end
        if (LINE_DONE !== 1'b0) begin bad++; $display("FAIL rst_done: got %b want 0", LINE_DONE); end
        if (BUSY !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", BUSY); end
        RST_N = 1'b1;
        PLB_DVAL = 1'b1;
        PLB_WIDX = 3'd0;
        PLB_DATA = 32'hFFFF_FFFF;
        tick();
        PLB_DVAL = 1'b0;
        total++;
        if (BUSY !== 1'b0 || FETCH_VAL !== 1'b0) begin
            bad++;
            $display("FAIL idle_dval: got busy=%b val=%b want 0 0", BUSY, FETCH_VAL);
        end
    endtask

    task automatic test_in_order();
        logic [31:0] d;
        start_fill(0);
        total++;
        if (BUSY !== 1'b1 || FETCH_VAL !== 1'b0) begin
            bad++;
            $display("FAIL io_start: got busy=%b val=%b want 1 0", BUSY, FETCH_VAL);
        end
        for (int i = 0; i < 8; i++) begin
            d = 32'h1000_0000 + 32'(i);
            PLB_DVAL = 1'b1;
            PLB_WIDX = 3'(i);
            PLB_DATA = d;
            q.push_back('{3'(i), d});
            tick();
            total++;
            if (FETCH_VAL !== 1'b1 || FETCH_IDX !== 3'(i) || LINE_DONE !== 1'b0) begin
                bad++;
                $display("FAIL io_present: got val=%b idx=%0d done=%b want 1 %0d 0",
                         FETCH_VAL, FETCH_IDX, LINE_DONE, i);
            end
        end
        PLB_DVAL = 1'b0;
        tick();
        total++;
        if (LINE_DONE !== 1'b1 || BUSY !== 1'b0 || FETCH_VAL !== 1'b0) begin
            bad++;
            $display("FAIL io_done: got done=%b busy=%b val=%b want 1 0 0",
                     LINE_DONE, BUSY, FETCH_VAL);
        end
        tick();
        total++;
        if (LINE_DONE !== 1'b0 || q.size() != 0) begin
            bad++;
            $display("FAIL io_pulse: got done=%b left=%0d want 0 0", LINE_DONE, q.size());
        end
    endtask

    task automatic test_wrap();
        logic [31:0] d;
        int          w;
        start_fill(5);
        for (int k = 0; k < 8; k++) begin
            w = (5 + k) % 8;
            d = 32'h5A00_0000 + 32'(w * 16);
            PLB_DVAL = 1'b1;
            PLB_WIDX = 3'(w);
            PLB_DATA = d;
            q.push_back('{3'(w), d});
            tick();
            total++;
            if (FETCH_VAL !== 1'b1 || FETCH_IDX !== 3'(w)) begin
                bad++;
                $display("FAIL wrap_order: got val=%b idx=%0d want 1 %0d",
                         FETCH_VAL, FETCH_IDX, w);
            end
        end
        PLB_DVAL = 1'b0;
        tick();
        total++;
        if (LINE_DONE !== 1'b1 || BUSY !== 1'b0) begin
            bad++;
            $display("FAIL wrap_done: got done=%b busy=%b want 1 0", LINE_DONE, BUSY);
        end
        FILL_START    = 1'b1;
        FILL_CRIT_IDX = 3'd3;
        tick();
        FILL_START    = 1'b0;
        total++;
        if (BUSY !== 1'b1 || FETCH_IDX !== 3'd3 || FETCH_VAL !== 1'b0) begin
            bad++;
            $display("FAIL start_in_done: got busy=%b idx=%0d val=%b want 1 3 0",
                     BUSY, FETCH_IDX, FETCH_VAL);
        end
        FILL_ABORT = 1'b1;
        tick();
        FILL_ABORT = 1'b0;
        tick();
    endtask

    task automatic test_out_of_order();
        int ord[3] = '{3, 1, 0};
        start_fill(0);
        for (int i = 0; i < 8; i++) begin
            q.push_back('{3'(i), 32'h7700_0000 + 32'(i)});
        end
        for (int k = 0; k < 3; k++) begin
            PLB_DVAL = 1'b1;
            PLB_WIDX = 3'(ord[k]);
            PLB_DATA = 32'h7700_0000 + 32'(ord[k]);
            tick();
            total++;
            if (FETCH_VAL !== (k == 2)) begin
                bad++;
                $display("FAIL ooo_wait: after write %0d got val=%b want %b",
                         ord[k], FETCH_VAL, (k == 2));
            end
        end
        PLB_DVAL = 1'b0;
        tick();
        total++;
        if (FETCH_VAL !== 1'b1 || FETCH_IDX !== 3'd1) begin
            bad++;
            $display("FAIL ooo_b2b: got val=%b idx=%0d want 1 1", FETCH_VAL, FETCH_IDX);
        end
        repeat (2) begin
            tick();
            total++;
            if (FETCH_VAL !== 1'b0 || FETCH_IDX !== 3'd2) begin
                bad++;
                $display("FAIL ooo_gap: got val=%b idx=%0d want 0 2", FETCH_VAL, FETCH_IDX);
            end
        end
        PLB_DVAL = 1'b1;
        PLB_WIDX = 3'd2;
        PLB_DATA = 32'h7700_0002;
        tick();
        total++;
        if (FETCH_VAL !== 1'b1 || FETCH_IDX !== 3'd2) begin
            bad++;
            $display("FAIL ooo_w2: got val=%b idx=%0d want 1 2", FETCH_VAL, FETCH_IDX);
        end
        for (int k = 4; k < 8; k++) begin
            PLB_WIDX = 3'(k);
            PLB_DATA = 32'h7700_0000 + 32'(k);
            tick();
            total++;
            if (FETCH_VAL !== 1'b1 || FETCH_IDX !== 3'(k - 1)) begin
                bad++;
                $display("FAIL ooo_tail: got val=%b idx=%0d want 1 %0d",
                         FETCH_VAL, FETCH_IDX, k - 1);
            end
        end
        PLB_DVAL = 1'b0;
        tick();
        tick();
        total++;
        if (LINE_DONE !== 1'b1 || q.size() != 0) begin
            bad++;
            $display("FAIL ooo_done: got done=%b left=%0d want 1 0", LINE_DONE, q.size());
        end
        tick();
    endtask

    task automatic test_hold();
        logic [31:0] d2;
        start_fill(0);
        FETCH_HOLD = 1'b1;
        for (int i = 0; i < 8; i++) begin
            PLB_DVAL = 1'b1;
            PLB_WIDX = 3'(i);
            PLB_DATA = 32'hA5A5_0000 + 32'(i * 3);
            q.push_back('{3'(i), 32'hA5A5_0000 + 32'(i * 3)});
            tick();
        end
        PLB_DVAL = 1'b0;
        FETCH_HOLD = 1'b0;
        repeat (2) tick();
        d2 = 32'hA5A5_0006;
        FETCH_HOLD = 1'b1;
        repeat (3) begin
            tick();
            total++;
            if (FETCH_IDX !== 3'd2 || FETCH_DATA !== d2 || FETCH_VAL !== 1'b1) begin
                bad++;
                $display("FAIL hold_stable: got idx=%0d data=%h val=%b want 2 %h 1",
                         FETCH_IDX, FETCH_DATA, FETCH_VAL, d2);
            end
        end
        FETCH_HOLD = 1'b0;
        repeat (5) tick();
        total++;
        if (FETCH_IDX !== 3'd7 || LINE_DONE !== 1'b0 || BUSY !== 1'b1) begin
            bad++;
            $display("FAIL hold_count: got idx=%0d done=%b busy=%b want 7 0 1",
                     FETCH_IDX, LINE_DONE, BUSY);
        end
        tick();
        total++;
        if (LINE_DONE !== 1'b1) begin
            bad++;
            $display("FAIL hold_done: got %b want 1", LINE_DONE);
        end
        tick();
    endtask

    task automatic test_abort();
        int w;
        start_fill(0);
        FETCH_HOLD = 1'b1;
        for (int i = 0; i < 8; i++) begin
            PLB_DVAL = 1'b1;
            PLB_WIDX = 3'(i);
            PLB_DATA = 32'h3000_0000 + 32'(i);
            q.push_back('{3'(i), 32'h3000_0000 + 32'(i)});
            tick();
        end
        PLB_DVAL = 1'b0;
        FETCH_HOLD = 1'b0;
        repeat (4) tick();
        total++;
        if (FETCH_IDX !== 3'd4 || q.size() != 4) begin
            bad++;
            $display("FAIL abort_pre: got idx=%0d left=%0d want 4 4", FETCH_IDX, q.size());
        end
        FILL_ABORT    = 1'b1;
        FILL_START    = 1'b1;
        FILL_CRIT_IDX = 3'd6;
        tick();
        FILL_ABORT = 1'b0;
        FILL_START = 1'b0;
        total++;
        if (BUSY !== 1'b0 || FETCH_VAL !== 1'b0 || LINE_DONE !== 1'b0) begin
            bad++;
            $display("FAIL abort_idle: got busy=%b val=%b done=%b want 0 0 0",
                     BUSY, FETCH_VAL, LINE_DONE);
        end
        tick();
        total++;
        if (BUSY !== 1'b0 || LINE_DONE !== 1'b0) begin
            bad++;
            $display("FAIL abort_after: got busy=%b done=%b want 0 0", BUSY, LINE_DONE);
        end
        q.delete();
        start_fill(2);
        for (int k = 0; k < 8; k++) begin
            w = (2 + k) % 8;
            PLB_DVAL = 1'b1;
            PLB_WIDX = 3'(w);
            PLB_DATA = 32'h4000_0000 + 32'(w);
            q.push_back('{3'(w), 32'h4000_0000 + 32'(w)});
            tick();
            total++;
            if (FETCH_VAL !== 1'b1 || FETCH_IDX !== 3'(w)) begin
                bad++;
                $display("FAIL abort_restart: got val=%b idx=%0d want 1 %0d",
                         FETCH_VAL, FETCH_IDX, w);
            end
        end
        PLB_DVAL = 1'b0;
        tick();
        total++;
        if (LINE_DONE !== 1'b1) begin
            bad++;
            $display("FAIL abort_redone: got %b want 1", LINE_DONE);
        end
        tick();
    endtask

    task automatic test_async_reset();
        start_fill(0);
        FETCH_HOLD = 1'b1;
        PLB_DVAL   = 1'b1;
        PLB_WIDX   = 3'd0;
        PLB_DATA   = 32'h5555_0000;
        tick();
        PLB_DVAL = 1'b0;
        total++;
        if (FETCH_VAL !== 1'b1) begin
            bad++;
            $display("FAIL arst_pre: got val=%b want 1", FETCH_VAL);
        end
        #2;
        RST_N = 1'b0;
        #1;
        total++;
        if (FETCH_VAL !== 1'b0 || BUSY !== 1'b0 || LINE_DONE !== 1'b0) begin
            bad++;
            $display("FAIL arst_async: got val=%b busy=%b done=%b want 0 0 0",
                     FETCH_VAL, BUSY, LINE_DONE);
        end
        tick();
        RST_N = 1'b1;
        tick();
        start_fill(0);
        PLB_DVAL = 1'b1;
        PLB_WIDX = 3'd0;
        PLB_DATA = 32'hCAFE_0000;
        q.push_back('{3'd0, 32'hCAFE_0000});
        tick();
        PLB_DATA = 32'hDEAD_0000;
        tick();
        PLB_DVAL = 1'b0;
        total++;
        if (FETCH_IDX !== 3'd0 || FETCH_DATA !== 32'hCAFE_0000) begin
            bad++;
            $display("FAIL arst_dup: got idx=%0d data=%h want 0 cafe0000",
                     FETCH_IDX, FETCH_DATA);
        end
        FETCH_HOLD = 1'b0;
        for (int i = 1; i < 8; i++) begin
            PLB_DVAL = 1'b1;
            PLB_WIDX = 3'(i);
            PLB_DATA = 32'h6000_0000 + 32'(i);
            q.push_back('{3'(i), 32'h6000_0000 + 32'(i)});
            tick();
            total++;
            if (FETCH_VAL !== 1'b1 || FETCH_IDX !== 3'(i)) begin
                bad++;
                $display("FAIL arst_line: got val=%b idx=%0d want 1 %0d",
                         FETCH_VAL, FETCH_IDX, i);
            end
        end
        PLB_DVAL = 1'b0;
        tick();
        total++;
        if (LINE_DONE !== 1'b1 || q.size() != 0) begin
            bad++;
            $display("FAIL arst_done: got done=%b left=%0d want 1 0", LINE_DONE, q.size());
        end
        tick();
    endtask

    initial begin
        RST_N         = 1'b0;
        FILL_START    = 1'b0;
        FILL_CRIT_IDX = 3'd0;
        FILL_ABORT    = 1'b0;
        PLB_DVAL      = 1'b0;
        PLB_WIDX      = 3'd0;
        PLB_DATA      = 32'h0;
        FETCH_HOLD    = 1'b0;
        test_reset();
        test_in_order();
        test_wrap();
        test_out_of_order();
        test_hold();
        test_abort();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
